// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
//   Shared definitions for the APB requester and its helpers.
//   - apb_master_state_t : requester FSM states (IDLE, SETUP, ACCESS, RESP)
//   - APB_ADDR_W/DATA_W  : default address / data widths
//   - apb_rsp_t          : one response as seen on the rsp_* interface
// -----------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_master_state_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
//   Counts ACCESS cycles spent waiting for pready and flags the last allowed
//   cycle so the requester can abort a stuck transfer.
//
//   Ports:
//     clk      in   clock (rising edge)
//     rst      in   synchronous active-high reset
//     clear    in   restart the count (asserted in the cycle before ACCESS)
//     count_en in   high while the requester sits in ACCESS
//     expired  out  high during the LIMIT-th ACCESS cycle; if pready is still
//                   low in that cycle the transfer is aborted at its end
// -----------------------------------------------------------------------------
module apb_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    // Holds values 0 .. LIMIT-1; one extra bit of headroom keeps LIMIT=1 legal.
    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // count = number of ACCESS cycles already completed in this transfer.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = count_en && (count >= CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//   APB3 requester. Accepts one command at a time on a valid/ready interface,
//   runs the SETUP/ACCESS sequence on the APB bus and returns the result on a
//   held response interface.
//
//   Handshake semantics (both interfaces): a transfer happens on a rising pclk
//   edge where valid && ready are both high. cmd_* is only looked at in IDLE;
//   rsp_* stays stable from rsp_valid rising until the edge where rsp_ready is
//   seen high. rsp_ready while rsp_valid is low is ignored.
//
//   Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase
//   that has waited TIMEOUT_CYCLES cycles for pready. Without it the requester
//   waits for pready indefinitely and rsp_timeout is constant 0.
//
//   Ports:
//     pclk, preset          clock, synchronous active-high reset
//     cmd_valid/cmd_ready   command handshake
//     cmd_write/addr/wdata  command payload
//     rsp_valid/rsp_ready   response handshake
//     rsp_rdata/err/timeout response payload
//     psel/penable/pwrite/paddr/pwdata   APB requester outputs (registered)
//     prdata/pready/pslverr              APB completer inputs
// -----------------------------------------------------------------------------
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              preset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,

    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be at least 1");
    end

    apb_master_state_t state;

    // High in the ACCESS cycle that is the last one allowed to wait.
    logic timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (pclk),
        .rst      (preset),
        .clear    (state == SETUP),
        .count_en (state == ACCESS),
        .expired  (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Ready is a pure function of state so a command can be offered in the
    // same cycle the requester returns to IDLE; gated so reset never accepts.
    assign cmd_ready = (state == IDLE) && !preset;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite  <= cmd_write;
                        paddr   <= cmd_addr;
                        // Reads drive zero write data so pwdata never leaks
                        // a stale or unrelated value onto the bus.
                        pwdata  <= cmd_write ? cmd_wdata : '0;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end

                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    // A completion in the final allowed cycle wins over the
                    // timeout, so pready is checked first.
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that turns a simple valid/ready command interface into APB3 SETUP/ACCESS transfers toward APB responders such as the team's APB RAM.
- Issues one transfer at a time and returns read data and error status on a held response interface.
- Sits between an internal controller or test sequencer and the APB bus.

Parameters:
ADDR_W, 32, paddr / cmd_addr width
DATA_W, 32, pwdata / prdata / cmd_wdata / rsp_rdata width
TIMEOUT_CYCLES, 16, max ACCESS cycles waiting for pready (used only with timeout feature; must be >=1)

Ports:
pclk  in  1  clock; all logic on rising edge
preset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a pclk edge
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response available; held until rsp_ready
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data; 0 for writes and errored reads
rsp_err  out  1  pslverr seen, or timeout
rsp_timeout  out  1  transfer aborted by timeout (tied 0 when feature disabled)
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready / wait-state control
pslverr  in  1  APB slave error

Behaviour:
- Clocking and reset: one clock `pclk`. Reset `preset` is synchronous and active-high. All APB and rsp outputs are registered.
- While preset is high:
  - psel, penable, pwrite, rsp_valid, rsp_err and rsp_timeout are 0.
  - paddr, pwdata and rsp_rdata are 0.
  - cmd_ready is 0.
  - State is IDLE.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1 (combinational from state, gated by !preset).
  - On handshake: latch cmd_write into pwrite and cmd_addr into paddr.
  - Latch cmd_wdata into pwdata for writes; pwdata = 0 for reads.
  - Set psel = 1, penable = 0, then go to SETUP.
- SETUP: exactly one cycle (psel = 1, penable = 0). Next edge sets penable = 1 and goes to ACCESS.
- ACCESS:
  - psel = penable = 1. paddr, pwrite and pwdata stay stable for the whole of ACCESS.
  - pready and pslverr are sampled only in ACCESS.
  - pready = 0: stay in ACCESS (wait state).
  - pready = 1:
    - Drop psel and penable.
    - rsp_err = pslverr.
    - rsp_rdata = prdata if read and !pslverr, else 0.
    - Set rsp_valid = 1, go to RESP.
- RESP:
  - rsp_valid stays 1 and rsp fields stay stable until rsp_ready = 1.
  - On that edge clear rsp_valid and go to IDLE.
  - cmd_ready = 0 throughout RESP.
- Latency, zero wait states:
  - Accept at edge E0.
  - SETUP in cycle after E0.
  - ACCESS after E1.
  - rsp_valid visible after E2.
  - Each wait state adds 1 cycle.
- Throughput: at most one transfer per 4 cycles (IDLE, SETUP, ACCESS, RESP).
- cmd_* inputs are ignored outside the IDLE handshake.
- rsp_ready while rsp_valid = 0 has no effect.
- Reset mid-transfer: psel and penable drop on that edge. No response is generated and the in-flight command is discarded.
- pready must not be high with psel = 0; the master ignores it.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Enabled:
  - An ACCESS-cycle counter clears on entering ACCESS.
  - If pready is still 0 after TIMEOUT_CYCLES ACCESS cycles, the master forces the same exit as a completion: psel/penable drop, go to RESP.
  - The response is rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - A pready = 1 in the final allowed cycle counts as normal completion.
- Disabled:
  - No counter is built and rsp_timeout is tied 0.
  - The master waits in ACCESS indefinitely.

Decomposition:
- Shared package apb_pkg holds:
  - the state enum apb_master_state_t (IDLE, SETUP, ACCESS, RESP);
  - default width constants APB_ADDR_W = 32 and APB_DATA_W = 32;
  - a response struct {rdata, err, timeout}.
- Sub-module apb_wait_timer holds the timeout counter (clear, count-enable, expired). It is instantiated only under APB_MASTER_TIMEOUT_EN.

Test Plan:
- Write addr 0x05, data 0xDEADBEEF, zero-wait slave, rsp_ready = 1 -> psel rises the cycle after accept and penable one cycle later. rsp_valid appears 3 cycles after accept with rsp_err = 0 and rsp_rdata = 0.
- Read back addr 0x05 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0. paddr and pwrite stay stable across SETUP and ACCESS.
- Read addr 40 with slave asserting pslverr -> rsp_err = 1, rsp_rdata = 0.
- Slave inserts 3 wait states on a write to addr 0x02 -> ACCESS lasts 4 cycles with stable paddr/pwdata, and rsp_valid comes 6 cycles after accept. Holding rsp_ready = 0 for 5 cycles keeps rsp_valid and the data stable, with cmd_ready = 0.
- preset asserted during ACCESS -> psel and penable are 0 after that edge, rsp_valid never rises, and cmd_ready = 1 after preset falls.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES = 4, pready held 0 -> after 4 ACCESS cycles the response is rsp_err = 1, rsp_timeout = 1. A second run with pready = 1 in the 4th cycle completes normally with rsp_timeout = 0.
